mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU instruction-fetch port and data-memory port.
- Grants at most one access per cycle. Data port has priority, bounded by an anti-starvation streak counter.
- Tracks the in-flight read and routes read data back to its owner, holding the last word per port.
- Sits between the CPU pipeline (fetch/MEM stages) and the memory macro; the CPU stalls on missing grants.

Parameters:
- ADDR_W, 14, SRAM word-address width (byte address bits [ADDR_W+1:2] are used).
- DATA_W, 32, data word width.
- STREAK_MAX, 4, maximum consecutive data-port grants while fetch is waiting (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- im_req  in  1  fetch read request; held with im_addr until im_gnt
- im_addr  in  32  fetch byte address
- im_kill  in  1  drop the in-flight fetch read (branch redirect)
- im_gnt  out  1  fetch request accepted this cycle
- im_rvalid  out  1  fetch data valid (cycle after grant)
- im_rdata  out  DATA_W  fetch data; holds last returned word
- dm_req  in  1  data request; held with all dm_* inputs until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_bweb  in  DATA_W  active-low bit write enables
- dm_addr  in  32  data byte address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted; writes complete at grant
- dm_rvalid  out  1  load data valid (cycle after grant)
- dm_rdata  out  DATA_W  load data; holds last returned word
- sram_ceb  out  1  active-low chip enable
- sram_web  out  1  active-low write enable
- sram_bweb  out  DATA_W  active-low bit write enables
- sram_a  out  ADDR_W  word address
- sram_di  out  DATA_W  write data
- sram_do  in  DATA_W  read data, valid the cycle after a read is enabled

Behaviour:
- Arbitration is combinational from requests and registered state.
- dm_req wins unless im_req is set and streak == STREAK_MAX; then im wins.
- streak counter:
  - increments on each dm grant while im_req=1;
  - clears on any im grant, or any cycle with im_req=0;
  - saturates at STREAK_MAX.
- On a grant, sram_ceb=0, and sram_a, sram_web (=~dm_we for data, 1 for fetch), sram_bweb and sram_di are driven from the winner.
- With no grant: sram_ceb=1, sram_web=1, sram_bweb all ones, address/data 0.
- Read tracking register rd_owner ∈ {NONE, IM, DM}:
  - set to IM on an im grant, to DM on a dm read grant, to NONE otherwise;
  - this gives back-to-back issue every cycle (no bubble).
- rvalid/rdata routing:
  - im_rvalid = (rd_owner==IM) & ~kill_q; dm_rvalid = (rd_owner==DM).
  - Each rdata = sram_do when its rvalid=1, else the value in its hold register.
  - Hold registers capture sram_do on the rvalid cycle.
- im_kill:
  - asserted in the grant cycle or the following cycle, it suppresses that fetch's im_rvalid and the hold-register update;
  - kill_q registers "kill seen" for the in-flight fetch;
  - im_kill with no fetch in flight has no effect.
- A dm write grant never produces dm_rvalid.
- Simultaneous requests with streak saturated: im granted, dm_gnt=0, dm_req must stay held.
- Reset (asynchronous, mid-operation included): rd_owner=NONE, streak=0, kill_q=0, hold registers=0, counters=0.
  - All rvalid=0 and all gnt outputs follow requests combinationally.
  - A read in flight at reset is discarded.
- Addresses outside ADDR_W range are truncated (no error).

Optional Feature:
- ARB_PERF_CNT_EN adds outputs perf_conflict (32) and perf_im_starve (32).
  - perf_conflict counts cycles with both requests high.
  - perf_im_starve counts cycles with im_req=1 and im_gnt=0.
  - Both wrap at 2^32.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg: rd_owner_e enum (NONE/IM/DM), default ADDR_W/DATA_W constants, idle SRAM drive constants.
- One sub-module, arb_streak_ctr: saturating streak counter with priority-override output.

Test Plan:
- im_req only, addr 0x40, sram_do=0xDEADBEEF next cycle -> im_gnt same cycle, sram_a=0x10, im_rvalid=1 and im_rdata=0xDEADBEEF next cycle, held afterwards.
- Both req continuous, dm reads, STREAK_MAX=4 -> grant pattern DM,DM,DM,DM,IM repeating; dm_gnt=0 on the IM cycle.
- dm write addr 0x8, bweb=0xFFFF0000, wdata=0x1234 -> sram_ceb=0, sram_web=0, sram_bweb=0xFFFF0000, dm_gnt=1, no dm_rvalid next cycle.
- im grant then im_kill the next cycle -> im_rvalid=0, im_rdata keeps the previous word; a dm read granted in the same cycle still returns dm_rvalid.
- rst low during in-flight dm read -> dm_rvalid=0, dm_rdata=0, streak=0; after release a new im request is granted immediately.
- ARB_PERF_CNT_EN on, 10 cycles both requests -> perf_conflict=10, perf_im_starve=8 with STREAK_MAX=4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STREAK_W   = 4;

  // Which port the read launched last cycle belongs to.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_IM   = 2'd1,
    RD_DM   = 2'd2
  } rd_owner_e;

  localparam logic SRAM_CEB_IDLE = 1'b1;
  localparam logic SRAM_WEB_IDLE = 1'b1;

endpackage

// File: rtl/arb_streak_ctr.sv
// Counts consecutive data-port grants while fetch waits; saturation hands priority to fetch.
module arb_streak_ctr import mem_arb_pkg::*; #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic im_req_i,
  input  logic dm_gnt_i,
  input  logic im_gnt_i,
  output logic im_prio_o
);

  localparam logic [STREAK_W-1:0] SAT = STREAK_W'(STREAK_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // NOTE: default assignment first so every path drives streak_d and no latch is inferred.
  always_comb begin
    streak_d = streak_q;
    if (im_gnt_i || !im_req_i) begin
      streak_d = '0;
    end else if (dm_gnt_i && (streak_q != SAT)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign im_prio_o = (streak_q == SAT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch and data ports with bounded data priority.
// Define ARB_PERF_CNT_EN to add the perf_conflict / perf_im_starve event counters.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_req,
  input  logic [31:0]       im_addr,
  input  logic              im_kill,
  output logic              im_gnt,
  output logic              im_rvalid,
  output logic [DATA_W-1:0] im_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_bweb,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [DATA_W-1:0] sram_bweb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_im_starve
`endif
);

  logic              im_prio;
  rd_owner_e         rd_owner_q, rd_owner_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] im_hold_q, dm_hold_q;

  arb_streak_ctr #(.STREAK_MAX(STREAK_MAX)) u_streak (
    .clk       (clk),
    .rst_n     (rst),
    .im_req_i  (im_req),
    .dm_gnt_i  (dm_gnt),
    .im_gnt_i  (im_gnt),
    .im_prio_o (im_prio)
  );

  assign dm_gnt = dm_req & ~(im_req & im_prio);
  assign im_gnt = im_req & ~dm_gnt;

  always_comb begin
    sram_ceb  = SRAM_CEB_IDLE;
    sram_web  = SRAM_WEB_IDLE;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    if (dm_gnt) begin
      sram_ceb  = 1'b0;
      sram_web  = ~dm_we;
      sram_bweb = dm_bweb;
      sram_a    = dm_addr[ADDR_W+1:2];
      sram_di   = dm_wdata;
    end else if (im_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = im_addr[ADDR_W+1:2];
    end
  end

  // A redirect in the grant cycle is remembered; one in the return cycle acts directly.
  always_comb begin
    rd_owner_d = RD_NONE;
    if (im_gnt) begin
      rd_owner_d = RD_IM;
    end else if (dm_gnt && !dm_we) begin
      rd_owner_d = RD_DM;
    end
    kill_d = im_gnt & im_kill;
  end

  assign im_rvalid = (rd_owner_q == RD_IM) & ~kill_q & ~im_kill;
  assign dm_rvalid = (rd_owner_q == RD_DM);
  assign im_rdata  = im_rvalid ? sram_do : im_hold_q;
  assign dm_rdata  = dm_rvalid ? sram_do : dm_hold_q;

  // NOTE: hold registers are reset so rdata reads zero until the first return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_q <= RD_NONE;
      kill_q     <= 1'b0;
      im_hold_q  <= '0;
      dm_hold_q  <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      kill_q     <= kill_d;
      if (im_rvalid) im_hold_q <= sram_do;
      if (dm_rvalid) dm_hold_q <= sram_do;
    end
  end

  logic conflict_ev, starve_ev;
  assign conflict_ev = im_req & dm_req;
  assign starve_ev   = im_req & ~im_gnt;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_q, perf_im_starve_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_conflict_q  <= '0;
      perf_im_starve_q <= '0;
    end else begin
      if (conflict_ev) perf_conflict_q  <= perf_conflict_q + 32'd1;
      if (starve_ev)   perf_im_starve_q <= perf_im_starve_q + 32'd1;
    end
  end

  assign perf_conflict  = perf_conflict_q;
  assign perf_im_starve = perf_im_starve_q;
`else
  logic unused_perf_ev;
  assign unused_perf_ev = conflict_ev ^ starve_ev;
`endif

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{im_addr[31:ADDR_W+2], im_addr[1:0],
                              dm_addr[31:ADDR_W+2], dm_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: SRAM model, read-data scoreboard, grant/drive checks.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        im_req, im_kill, im_gnt, im_rvalid;
  logic [31:0] im_addr, im_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_bweb, dm_addr, dm_wdata, dm_rdata;
  logic        sram_ceb, sram_web;
  logic [31:0] sram_bweb, sram_di, sram_do;
  logic [13:0] sram_a;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict, perf_im_starve;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] im_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] mem [0:63];

  mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_kill(im_kill), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_bweb(dm_bweb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict(perf_conflict), .perf_im_starve(perf_im_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM macro: registered read, bit-masked write (bweb active low).
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
    mem[16] = 32'hDEAD_BEEF;
    sram_do = '0;
  end
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a[5:0]] = (mem[sram_a[5:0]] & sram_bweb) | (sram_di & ~sram_bweb);
      else           sram_do <= mem[sram_a[5:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pops one expected word for that port.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (im_rvalid) begin
          if (im_q.size() == 0) check("im_rvalid_unexpected", 32'(im_rvalid), 32'd0);
          else begin e = im_q.pop_front(); check("im_rdata_sb", im_rdata, e); end
        end
        if (dm_rvalid) begin
          if (dm_q.size() == 0) check("dm_rvalid_unexpected", 32'(dm_rvalid), 32'd0);
          else begin e = dm_q.pop_front(); check("dm_rdata_sb", dm_rdata, e); end
        end
      end
    end
  end

  task automatic step(input logic ireq, input logic [31:0] iaddr, input logic kill,
                      input logic dreq, input logic dwe, input logic [31:0] daddr,
                      input logic [31:0] dbweb, input logic [31:0] dwd,
                      input logic exp_ig, input logic exp_dg,
                      input logic push_i, input logic [31:0] exp_i,
                      input logic push_d, input logic [31:0] exp_d, input string tag);
    @(posedge clk);
    #1;
    im_req = ireq; im_addr = iaddr; im_kill = kill;
    dm_req = dreq; dm_we = dwe; dm_addr = daddr; dm_bweb = dbweb; dm_wdata = dwd;
    #3;
    check({tag, "_im_gnt"}, 32'(im_gnt), 32'(exp_ig));
    check({tag, "_dm_gnt"}, 32'(dm_gnt), 32'(exp_dg));
    if (push_i) im_q.push_back(exp_i);
    if (push_d) dm_q.push_back(exp_d);
  endtask

  task automatic idle(input logic kill, input string tag);
    step(1'b0, 32'h0, kill, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0,
         1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, tag);
  endtask

  initial begin
    rst = 1'b0;
    im_req = 0; im_addr = 0; im_kill = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_bweb = '1; dm_wdata = 0;
    #1;
    check("rst_im_rvalid", 32'(im_rvalid), 32'd0);
    check("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("rst_im_rdata", im_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_sram_ceb", 32'(sram_ceb), 32'd1);
    check("rst_sram_web", 32'(sram_web), 32'd1);
    check("rst_sram_bweb", sram_bweb, 32'hFFFF_FFFF);
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_sram_di", sram_di, 32'd0);
    im_req = 1; #1;
    check("rst_comb_im_gnt", 32'(im_gnt), 32'd1);
    dm_req = 1; #1;
    check("rst_comb_dm_gnt", 32'(dm_gnt), 32'd1);
    check("rst_comb_im_lose", 32'(im_gnt), 32'd0);
    im_req = 0; dm_req = 0;
    #5 rst = 1'b1;

    // Single fetch read and hold.
    step(1, 32'h40, 0, 0, 0, 0, '1, 0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0, "fetch");
    check("fetch_sram_a", 32'(sram_a), 32'h10);
    check("fetch_sram_ceb", 32'(sram_ceb), 32'd0);
    check("fetch_sram_web", 32'(sram_web), 32'd1);
    idle(0, "fetch_ret");
    check("fetch_rvalid", 32'(im_rvalid), 32'd1);
    check("fetch_rdata", im_rdata, 32'hDEAD_BEEF);
    check("idle_sram_ceb", 32'(sram_ceb), 32'd1);
    check("idle_sram_a", 32'(sram_a), 32'd0);
    idle(0, "fetch_hold");
    check("fetch_hold_rvalid", 32'(im_rvalid), 32'd0);
    check("fetch_hold_rdata", im_rdata, 32'hDEAD_BEEF);

    // High address bits are truncated away.
    step(1, 32'hFFFF_0040, 0, 0, 0, 0, '1, 0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0, "trunc");
    check("trunc_sram_a", 32'(sram_a), 32'h10);

    // Both ports contending: DM x4 then IM, repeating.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) step(1, 32'h4, 0, 1, 0, 32'h0, '1, 0, 1, 0, 1, 32'h1000_0001, 0, 0, "streak");
      else            step(1, 32'h4, 0, 1, 0, 32'h0, '1, 0, 0, 1, 0, 0, 1, 32'h1000_0000, "streak");
    end
    idle(0, "streak_end");
`ifdef ARB_PERF_CNT_EN
    check("perf_conflict", perf_conflict, 32'd10);
    check("perf_im_starve", perf_im_starve, 32'd8);
`endif

    // Masked data write, then read it back.
    step(0, 0, 0, 1, 1, 32'h8, 32'hFFFF_0000, 32'h1234, 0, 1, 0, 0, 0, 0, "wr");
    check("wr_sram_ceb", 32'(sram_ceb), 32'd0);
    check("wr_sram_web", 32'(sram_web), 32'd0);
    check("wr_sram_bweb", sram_bweb, 32'hFFFF_0000);
    check("wr_sram_a", 32'(sram_a), 32'h2);
    check("wr_sram_di", sram_di, 32'h1234);
    idle(0, "wr_after");
    check("wr_no_rvalid", 32'(dm_rvalid), 32'd0);
    step(0, 0, 0, 1, 0, 32'h8, '1, 0, 0, 1, 0, 0, 1, 32'h1000_1234, "wr_rd");
    idle(0, "wr_rd_ret");

    // Kill in the return cycle; a data read granted that cycle still returns.
    step(1, 32'h14, 0, 0, 0, 0, '1, 0, 1, 0, 0, 0, 0, 0, "kill1");
    step(0, 0, 1, 1, 0, 32'hC, '1, 0, 0, 1, 0, 0, 1, 32'h1000_0003, "kill1_ret");
    check("kill1_rvalid", 32'(im_rvalid), 32'd0);
    check("kill1_rdata", im_rdata, 32'h1000_0001);
    idle(0, "kill1_after");
    check("kill1_hold", im_rdata, 32'h1000_0001);

    // Kill in the grant cycle.
    step(1, 32'h18, 1, 0, 0, 0, '1, 0, 1, 0, 0, 0, 0, 0, "kill2");
    idle(0, "kill2_ret");
    check("kill2_rvalid", 32'(im_rvalid), 32'd0);
    check("kill2_rdata", im_rdata, 32'h1000_0001);

    // Kill with nothing in flight leaves the next fetch untouched.
    idle(1, "kill3");
    step(1, 32'h1C, 0, 0, 0, 0, '1, 0, 1, 0, 1, 32'h1000_0007, 0, 0, "kill3_fetch");
    idle(0, "kill3_ret");
    check("kill3_rvalid", 32'(im_rvalid), 32'd1);
    check("kill3_rdata", im_rdata, 32'h1000_0007);

    // Build a streak, then reset with a data read in flight.
    step(1, 32'h4, 0, 1, 0, 32'h0, '1, 0, 0, 1, 0, 0, 1, 32'h1000_0000, "pre_rst");
    step(1, 32'h4, 0, 1, 0, 32'h0, '1, 0, 0, 1, 0, 0, 1, 32'h1000_0000, "pre_rst");
    step(1, 32'h4, 0, 1, 0, 32'h0, '1, 0, 0, 1, 0, 0, 0, 0, "pre_rst");
    @(posedge clk);
    #1;
    im_req = 0; dm_req = 0;
    #1 rst = 1'b0;
    #2;
    check("mid_rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("mid_rst_dm_rdata", dm_rdata, 32'd0);
    check("mid_rst_im_rdata", im_rdata, 32'd0);
    #4 rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (i == 4) step(1, 32'h4, 0, 1, 0, 32'h0, '1, 0, 1, 0, 1, 32'h1000_0001, 0, 0, "post_rst");
      else        step(1, 32'h4, 0, 1, 0, 32'h0, '1, 0, 0, 1, 0, 0, 1, 32'h1000_0000, "post_rst");
    end
    step(1, 32'h40, 0, 0, 0, 0, '1, 0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0, "post_rst_fetch");
    idle(0, "drain");
    idle(0, "drain");
    #2;
    check("im_q_drained", 32'(im_q.size()), 32'd0);
    check("dm_q_drained", 32'(dm_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
